// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } arb_state_t;

    localparam int CNT_W = 4;

    typedef logic req_idx_t;

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Combinational two-way round-robin pick: on a tie, the side not granted last wins.
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic     req0,
    input  logic     req1,
    input  req_idx_t last,
    output logic     valid,
    output req_idx_t winner
);

    assign valid  = req0 | req1;
    assign winner = (req0 && req1) ? req_idx_t'(~last) : req_idx_t'(req1);

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin owner of the single memory port; each transaction runs
// IDLE -> ACCESS (MEM_LATENCY cycles) -> DONE, with all outputs decoded from registers.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m1_req,
    input  logic        m0_we,
    input  logic        m1_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m0_wdata,
    input  logic [31:0] m1_wdata,
    output logic        m0_gnt,
    output logic        m1_gnt,
    output logic        m0_done,
    output logic        m1_done,
    output logic [31:0] m0_rdata,
    output logic [31:0] m1_rdata,
    output logic        memRead,
    output logic        memWrite,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

    arb_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    req_idx_t         owner_q, owner_d;
    req_idx_t         last_q, last_d;
    logic             we_q, we_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [31:0]      rdata0_q, rdata0_d;
    logic [31:0]      rdata1_q, rdata1_d;

    logic     pick_valid;
    req_idx_t pick_winner;

    rr_pick2 u_pick (
        .req0   (m0_req),
        .req1   (m1_req),
        .last   (last_q),
        .valid  (pick_valid),
        .winner (pick_winner)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        owner_d  = owner_q;
        last_d   = last_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    owner_d = pick_winner;
                    we_d    = pick_winner ? m1_we    : m0_we;
                    addr_d  = pick_winner ? m1_addr  : m0_addr;
                    wdata_d = pick_winner ? m1_wdata : m0_wdata;
                    cnt_d   = CNT_LOAD;
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (cnt_q == '0) begin
                    // Read data is taken on the final access edge only.
                    if (!we_q) begin
                        if (owner_q) rdata1_d = mem_rdata;
                        else         rdata0_d = mem_rdata;
                    end
                    last_d  = owner_q;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            owner_q  <= 1'b0;
            last_q   <= 1'b1;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    logic busy;
    assign busy      = (state_q == ST_ACCESS) || (state_q == ST_DONE);
    assign m0_gnt    = busy && !owner_q;
    assign m1_gnt    = busy &&  owner_q;
    assign m0_done   = (state_q == ST_DONE) && !owner_q;
    assign m1_done   = (state_q == ST_DONE) &&  owner_q;
    assign memRead   = (state_q == ST_ACCESS) && !we_q;
    assign memWrite  = (state_q == ST_ACCESS) &&  we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign m0_rdata  = rdata0_q;
    assign m1_rdata  = rdata1_q;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single memory port of the multicycle processor between two requesters: requester 0 is the CPU datapath's fetch/load/store path, requester 1 is a DMA/program-loader port. It sits between the processor top and the memory model. It drives `memRead`, `memWrite`, the address and the write data for one owner at a time. Arbitration is round-robin, and each transaction takes a fixed, parameterised number of memory cycles.

## Interface
- `MEM_LATENCY`, default 1: memory cycles a command is held before read data is sampled; legal range 1–15.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `m0_req`, `m1_req`  in  1 each: transaction request; held with its fields until the matching `done`.
- `m0_we`, `m1_we`  in  1 each: 1 = write, 0 = read.
- `m0_addr`, `m1_addr`  in  32 each: byte address.
- `m0_wdata`, `m1_wdata`  in  32 each: write data.
- `m0_gnt`, `m1_gnt`  out  1 each: requester currently owns the port.
- `m0_done`, `m1_done`  out  1 each: one-cycle completion pulse.
- `m0_rdata`, `m1_rdata`  out  32 each: captured read data; valid from `done` until that requester's next read completes.
- `memRead`, `memWrite`  out  1 each: memory command strobes.
- `mem_addr`, `mem_wdata`  out  32 each: memory address and write data.
- `mem_rdata`  in  32: memory read data.

## Operation
- The FSM has three states: IDLE, ACCESS and DONE.
- **IDLE**
  - No request pending: stay in IDLE.
  - Exactly one request pending: that requester wins.
  - Both pending: the requester that was not last granted wins.
  - The `last` pointer resets to 1, so m0 wins the first tie.
  - On a win: register `owner`, `we`, `addr` and `wdata`; load the counter with MEM_LATENCY−1; go to ACCESS.
- **ACCESS**
  - Drive `mem_addr` and `mem_wdata` from the registered fields.
  - Assert `memRead` when `we`=0 and `memWrite` when `we`=1; the two are never asserted together.
  - Assert the owner's `gnt`.
  - Decrement the counter each cycle.
  - In the cycle the counter is 0:
    - On a read, capture `mem_rdata` into the owner's rdata register.
    - Set `last` to the owner.
    - Go to DONE.
- **DONE**
  - Strobes are deasserted and `gnt` stays high.
  - The owner's `done` is high for exactly this cycle.
  - Next state is IDLE.
- On a write, rdata registers are unchanged.
- The non-owner's `gnt`, `done` and rdata never change while the other requester is served.
- `req` deasserted mid-transaction: the transaction still completes and `done` still pulses. Fields are taken from the registered copy, so input changes after the grant are ignored.
- Request fields change while `req` is held in IDLE: the values present in the granting cycle are used.
- `rst` at any point:
  - state becomes IDLE and `last` becomes 1;
  - `gnt`, `done`, `memRead` and `memWrite` become 0;
  - `mem_addr`, `mem_wdata` and both rdata registers become 0;
  - any in-flight transaction is abandoned with no `done`.

## Timing
- Reset values: all outputs are 0.
- Request sampled in IDLE at edge t:
  - `gnt` and the strobe are high from cycle t+1;
  - the strobe is high for MEM_LATENCY cycles;
  - `done` is high in cycle t+1+MEM_LATENCY;
  - IDLE again at t+2+MEM_LATENCY.
- Throughput: one transaction per MEM_LATENCY+2 cycles.
  - With `req` held continuously, the next grant is sampled in the IDLE cycle right after DONE.
  - With both requesting continuously, grants strictly alternate.
- `mem_rdata` is sampled on the last ACCESS edge and is visible on `mX_rdata` in the DONE cycle.
- Combinational paths:
  - outputs depend only on registers;
  - there is no combinational path from `req` to `gnt` or to the memory outputs.

## Structure
- Shared package `mem_arb_pkg`:
  - state enum (IDLE/ACCESS/DONE);
  - counter width constant (4 bits);
  - requester index type.
- One sub-module, `rr_pick2`: combinational two-way round-robin pick.
  - Inputs: `req0`, `req1`, `last`.
  - Outputs: `valid`, `winner`.
- The FSM, counter and registers live in `mem_port_arbiter`.

## Test plan
- MEM_LATENCY=1; m0 reads 0x40 with memory returning 0xDEADBEEF → `memRead` high for 1 cycle, `m0_done` 2 cycles after sampling, `m0_rdata`=0xDEADBEEF, `m1_*` unchanged.
- m0 and m1 both request continuously, MEM_LATENCY=3 → grants go m0, m1, m0, m1; each `done` is 5 cycles apart; `memRead` and `memWrite` are never high together.
- m1 writes 0x1234 to 0x80 while m0 is idle → `memWrite` high with `mem_addr`=0x80 and `mem_wdata`=0x1234; `m1_rdata` keeps its prior value.
- `rst` pulsed during the second ACCESS cycle of an m0 read → next cycle all outputs are 0, no `done`; a fresh tie afterwards grants m0.
- m0 drops `req` and changes `addr` after the grant cycle → memory sees the original address for all MEM_LATENCY cycles; `m0_done` still pulses.
